// File: rtl/adc_axis_sample_packer.sv
// Offset-binary ADC beats -> two's complement, optional 2^DECIM_LOG2 boxcar decimation,
// two 16-bit results packed per AXIS word with framed tlast. `ADC_PACKER_OVR_COUNT_EN builds ovr_count.
module adc_axis_sample_packer #(
    parameter int DECIM_LOG2  = 0,
    parameter int FRAME_WORDS = 256
) (
    input  logic        s00_axis_aclk,
    input  logic        s00_axis_areset,
    input  logic [31:0] s00_axis_tdata,
    input  logic        s00_axis_tvalid,
    output logic        s00_axis_tready,
    input  logic        s00_axis_tlast,
    output logic [31:0] m00_axis_tdata,
    output logic        m00_axis_tvalid,
    input  logic        m00_axis_tready,
    output logic        m00_axis_tlast,
    output logic [3:0]  m00_axis_tstrb,
    input  logic        clear,
    output logic [15:0] frame_count,
    output logic [15:0] ovr_count
);
    localparam int              PH_W      = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'((1 << DECIM_LOG2) - 1);
    localparam logic [15:0]     WORD_LAST = 16'(FRAME_WORDS - 1);

    function automatic logic signed [13:0] to_twos(input logic [13:0] code);
        return {~code[13], code[12:0]};
    endfunction

    // Arithmetic shift floors the boxcar mean; the result always fits in 16 bits.
    function automatic logic signed [15:0] decim_scale(input logic signed [17:0] sum);
        return 16'(sum >>> DECIM_LOG2);
    endfunction

    logic signed [17:0] acc_q, acc_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic signed [15:0] half_q, half_d;
    logic               half_vld_q, half_vld_d;
    logic [15:0]        word_cnt_q, word_cnt_d;
    logic [31:0]        out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic               out_vld_q, out_vld_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic               beat_acc;
    logic signed [13:0] x;
    logic signed [17:0] acc_sum;
    logic signed [15:0] result;
    logic               unused_bits;

    assign s00_axis_tready = !out_vld_q || m00_axis_tready;
    assign beat_acc        = s00_axis_tvalid && s00_axis_tready;
    assign x               = to_twos(s00_axis_tdata[13:0]);
    assign acc_sum         = acc_q + {{4{x[13]}}, x};
    assign result          = decim_scale(acc_sum);
    assign unused_bits     = ^{s00_axis_tdata[31:15], s00_axis_tlast};

    assign m00_axis_tdata  = out_data_q;
    assign m00_axis_tvalid = out_vld_q;
    assign m00_axis_tlast  = out_last_q;
    assign m00_axis_tstrb  = 4'hF;
    assign frame_count     = frame_cnt_q;

    always_comb begin
        acc_d       = acc_q;
        phase_d     = phase_q;
        half_d      = half_q;
        half_vld_d  = half_vld_q;
        word_cnt_d  = word_cnt_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_vld_d   = out_vld_q;
        frame_cnt_d = frame_cnt_q;

        if (out_vld_q && m00_axis_tready) begin
            out_vld_d = 1'b0;
            if (out_last_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end

        // clear drops partial state and the beat of this cycle, but never the output word.
        if (clear) begin
            acc_d      = '0;
            phase_d    = '0;
            half_vld_d = 1'b0;
            word_cnt_d = '0;
        end else if (beat_acc) begin
            if (phase_q == PH_LAST) begin
                acc_d   = '0;
                phase_d = '0;
                if (half_vld_q) begin
                    out_data_d = {result, half_q};
                    out_vld_d  = 1'b1;
                    out_last_d = (word_cnt_q == WORD_LAST);
                    word_cnt_d = (word_cnt_q == WORD_LAST) ? 16'd0 : word_cnt_q + 16'd1;
                    half_vld_d = 1'b0;
                end else begin
                    half_d     = result;
                    half_vld_d = 1'b1;
                end
            end else begin
                acc_d   = acc_sum;
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            acc_q       <= '0;
            phase_q     <= '0;
            half_q      <= '0;
            half_vld_q  <= 1'b0;
            word_cnt_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            half_vld_q  <= half_vld_d;
            word_cnt_q  <= word_cnt_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef ADC_PACKER_OVR_COUNT_EN
    logic [15:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (beat_acc && s00_axis_tdata[14] && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) ovr_q <= '0;
        else                 ovr_q <= ovr_d;
    end

    assign ovr_count = ovr_q;
`else
    logic unused_otr;
    assign unused_otr = s00_axis_tdata[14];
    assign ovr_count  = 16'd0;
`endif

endmodule

// File: tb/tb_adc_axis_sample_packer.sv
// Bench for adc_axis_sample_packer: instance 0 (DECIM_LOG2=0, FRAME_WORDS=4), instance 1 (DECIM_LOG2=2, FRAME_WORDS=3).
module tb_adc_axis_sample_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata [2];
    logic        s_tvalid[2], s_tready[2], s_tlast[2];
    logic [31:0] m_tdata [2];
    logic        m_tvalid[2], m_tready[2], m_tlast[2], clear[2];
    logic [3:0]  m_tstrb [2];
    logic [15:0] frame_count[2], ovr_count[2];

    always #5 clk = ~clk;

    adc_axis_sample_packer #(.DECIM_LOG2(0), .FRAME_WORDS(4)) u0 (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tdata(s_tdata[0]), .s00_axis_tvalid(s_tvalid[0]), .s00_axis_tready(s_tready[0]),
        .s00_axis_tlast(s_tlast[0]), .m00_axis_tdata(m_tdata[0]), .m00_axis_tvalid(m_tvalid[0]),
        .m00_axis_tready(m_tready[0]), .m00_axis_tlast(m_tlast[0]), .m00_axis_tstrb(m_tstrb[0]),
        .clear(clear[0]), .frame_count(frame_count[0]), .ovr_count(ovr_count[0]));

    adc_axis_sample_packer #(.DECIM_LOG2(2), .FRAME_WORDS(3)) u1 (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tdata(s_tdata[1]), .s00_axis_tvalid(s_tvalid[1]), .s00_axis_tready(s_tready[1]),
        .s00_axis_tlast(s_tlast[1]), .m00_axis_tdata(m_tdata[1]), .m00_axis_tvalid(m_tvalid[1]),
        .m00_axis_tready(m_tready[1]), .m00_axis_tlast(m_tlast[1]), .m00_axis_tstrb(m_tstrb[1]),
        .clear(clear[1]), .frame_count(frame_count[1]), .ovr_count(ovr_count[1]));

    int checks = 0;
    int failures = 0;

    // Reference model state: pending samples, held first result, word index in frame.
    int          sum_m[2], n_m[2], widx_m[2], frame_m[2], ovr_m[2];
    logic [15:0] half_m[2];
    bit          halfv_m[2];
    logic [32:0] expq0[$];
    logic [32:0] expq1[$];
    bit          stall_p[2];
    logic [31:0] stall_d[2];

    typedef struct {
        int          inst;
        logic [13:0] a;
        logic [13:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[7];

    function automatic int n_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int fw_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    function automatic int fdiv(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int exp_ovr(input int i);
`ifdef ADC_PACKER_OVR_COUNT_EN
        return ovr_m[i];
`else
        return (i < 0) ? 1 : 0;
`endif
    endfunction

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h t=%0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int i);
        sum_m[i] = 0; n_m[i] = 0; halfv_m[i] = 1'b0; widx_m[i] = 0;
    endtask

    task automatic model_reset(input int i);
        model_clear(i);
        frame_m[i] = 0; ovr_m[i] = 0; stall_p[i] = 1'b0;
        if (i == 0) expq0.delete(); else expq1.delete();
    endtask

    task automatic model_beat(input int i, input logic [13:0] code);
        int          r;
        logic [32:0] e;
        sum_m[i] += int'(code) - 8192;
        n_m[i]++;
        if (n_m[i] == n_of(i)) begin
            r = fdiv(sum_m[i], n_of(i));
            sum_m[i] = 0; n_m[i] = 0;
            if (!halfv_m[i]) begin
                half_m[i] = r[15:0]; halfv_m[i] = 1'b1;
            end else begin
                e = {(widx_m[i] % fw_of(i)) == fw_of(i) - 1, r[15:0], half_m[i]};
                widx_m[i]++;
                halfv_m[i] = 1'b0;
                if (i == 0) expq0.push_back(e); else expq1.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        logic [32:0] e;
        bit          acc, empty;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    model_reset(i);
                end else begin
                    chk("frame_count", i, 64'(frame_count[i]), 64'(frame_m[i]));
                    chk("ovr_count", i, 64'(ovr_count[i]), 64'(exp_ovr(i)));
                    chk("s_tready", i, 64'(s_tready[i]), 64'(!m_tvalid[i] || m_tready[i]));
                    if (stall_p[i]) begin
                        chk("stall_tvalid", i, 64'(m_tvalid[i]), 64'd1);
                        chk("stall_tdata", i, 64'(m_tdata[i]), 64'(stall_d[i]));
                    end
                    stall_p[i] = m_tvalid[i] && !m_tready[i];
                    stall_d[i] = m_tdata[i];
                    if (m_tvalid[i] && m_tready[i]) begin
                        empty = (i == 0) ? (expq0.size() == 0) : (expq1.size() == 0);
                        if (empty) begin
                            checks++; failures++;
                            $display("FAIL word_unexpected inst=%0d actual=%h required=none", i, m_tdata[i]);
                        end else begin
                            e = (i == 0) ? expq0.pop_front() : expq1.pop_front();
                            chk("word_data", i, 64'(m_tdata[i]), 64'(e[31:0]));
                            chk("word_last", i, 64'(m_tlast[i]), 64'(e[32]));
                            if (e[32]) frame_m[i] = (frame_m[i] + 1) % 65536;
                        end
                    end
                    acc = s_tvalid[i] && s_tready[i];
                    if (acc && s_tdata[i][14] && ovr_m[i] < 65535) ovr_m[i]++;
                    if (clear[i]) model_clear(i);
                    else if (acc) model_beat(i, s_tdata[i][13:0]);
                end
            end
        end
    endtask

    task automatic send(input int i, input logic [13:0] code, input logic otr);
        int k;
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = {17'd0, otr, code};
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_tready[i]) break;
        end
        checks++;
        if (k == 100) begin
            failures++;
            $display("FAIL send_timeout inst=%0d actual=tready_low required=tready_high", i);
        end
        @(posedge clk); #1;
        s_tvalid[i] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        time t0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tlast[i] = 1'b0;
            m_tready[i] = 1'b0; clear[i] = 1'b0;
        end
        rst = 1'b1;
        s_tvalid[0] = 1'b1; s_tdata[0] = 32'h0000_7FFF;
        fork monitor(); join_none

        // Reset state, with an ignored beat presented during reset.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tvalid", i, 64'(m_tvalid[i]), 64'd0);
            chk("rst_tdata", i, 64'(m_tdata[i]), 64'd0);
            chk("rst_tlast", i, 64'(m_tlast[i]), 64'd0);
            chk("rst_frame", i, 64'(frame_count[i]), 64'd0);
            chk("rst_ovr", i, 64'(ovr_count[i]), 64'd0);
            chk("rst_tready", i, 64'(s_tready[i]), 64'd1);
            chk("tstrb", i, 64'(m_tstrb[i]), 64'hF);
        end
        @(posedge clk); #1;
        s_tvalid[0] = 1'b0;
        m_tready[0] = 1'b1; m_tready[1] = 1'b1;
        rst = 1'b0;

        // Conversion, packing, decimation vectors.
        tbl[0] = '{0, 14'h2000, 14'h3FFF, 32'h1FFF_0000};
        tbl[1] = '{0, 14'h0000, 14'h2001, 32'h0001_E000};
        tbl[2] = '{0, 14'h3FFF, 14'h0000, 32'hE000_1FFF};
        tbl[3] = '{0, 14'h1FFF, 14'h2000, 32'h0000_FFFF};
        tbl[4] = '{1, 14'h2004, 14'h2004, 32'h0004_0004};
        tbl[5] = '{1, 14'h1FFF, 14'h2000, 32'h0000_FFFF};
        tbl[6] = '{1, 14'h0000, 14'h3FFF, 32'h1FFF_E000};
        for (int v = 0; v < 7; v++) begin
            for (int r = 0; r < n_of(tbl[v].inst); r++) send(tbl[v].inst, tbl[v].a, 1'b0);
            for (int r = 0; r < n_of(tbl[v].inst); r++) send(tbl[v].inst, tbl[v].b, 1'b0);
            chk("vec_tvalid", v, 64'(m_tvalid[tbl[v].inst]), 64'd1);
            chk("vec_tdata", v, 64'(m_tdata[tbl[v].inst]), 64'(tbl[v].exp));
        end
        repeat (2) @(posedge clk); #1;
        chk("vec_frames", 1, 64'(frame_count[1]), 64'd1);

        // Framing and throughput: 16 back-to-back beats, two more frames.
        t0 = $time;
        for (int k = 0; k < 16; k++) send(0, 14'($urandom), 1'b0);
        chk("throughput_cycles", 0, 64'(($time - t0) / 10), 64'd16);
        repeat (2) @(posedge clk); #1;
        chk("frame_count_after16", 0, 64'(frame_count[0]), 64'd3);

        // Backpressure: stalled word holds, input stalls, nothing lost on release.
        send(0, 14'h2100, 1'b0); send(0, 14'h2101, 1'b0);
        @(posedge clk); #1;
        m_tready[0] = 1'b0;
        send(0, 14'h2102, 1'b0); send(0, 14'h2103, 1'b0);
        chk("bp_tready_drop", 0, 64'(s_tready[0]), 64'd0);
        s_tvalid[0] = 1'b1; s_tdata[0] = 32'h0000_2104;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_stall_tready", 0, 64'(s_tready[0]), 64'd0);
            chk("bp_stall_tdata", 0, 64'(m_tdata[0]), 64'h0103_0102);
        end
        @(posedge clk); #1;
        m_tready[0] = 1'b1;
        send(0, 14'h2104, 1'b0); send(0, 14'h2105, 1'b0);
        chk("bp_resume", 0, 64'(m_tdata[0]), 64'h0105_0104);

        // clear mid-pair: held half and the clear-cycle beat both vanish; frame restarts.
        @(posedge clk); #1;
        send(0, 14'h1234, 1'b0);
        s_tvalid[0] = 1'b1; s_tdata[0] = 32'h0000_1111; clear[0] = 1'b1;
        @(posedge clk); #1;
        s_tvalid[0] = 1'b0; clear[0] = 1'b0;
        send(0, 14'h2000, 1'b0); send(0, 14'h2001, 1'b0);
        chk("clr_tdata", 0, 64'(m_tdata[0]), 64'h0001_0000);
        chk("clr_tlast0", 0, 64'(m_tlast[0]), 64'd0);
        for (int k = 0; k < 6; k++) send(0, 14'(14'h2010 + k), 1'b0);
        chk("clr_tlast3", 0, 64'(m_tlast[0]), 64'd1);

        // Over-range counter, survives clear, cleared by reset mid-frame.
        for (int k = 0; k < 3; k++) send(0, 14'h2000, 1'b1);
        repeat (2) @(posedge clk); #1;
`ifdef ADC_PACKER_OVR_COUNT_EN
        chk("ovr_3", 0, 64'(ovr_count[0]), 64'd3);
`else
        chk("ovr_tied0", 0, 64'(ovr_count[0]), 64'd0);
`endif
        clear[0] = 1'b1;
        @(posedge clk); #1;
        clear[0] = 1'b0;
        @(negedge clk);
`ifdef ADC_PACKER_OVR_COUNT_EN
        chk("ovr_after_clear", 0, 64'(ovr_count[0]), 64'd3);
`else
        chk("ovr_after_clear", 0, 64'(ovr_count[0]), 64'd0);
`endif
        @(posedge clk); #1;
        send(0, 14'h2222, 1'b0); send(0, 14'h2223, 1'b0); send(0, 14'h2224, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", 0, 64'(m_tvalid[0]), 64'd0);
        chk("midrst_ovr", 0, 64'(ovr_count[0]), 64'd0);
        chk("midrst_frame", 0, 64'(frame_count[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) send(0, 14'(14'h2300 + k), 1'b0);
        chk("midrst_tlast", 0, 64'(m_tlast[0]), 64'd1);
        chk("midrst_tdata", 0, 64'(m_tdata[0]), 64'h0307_0306);

        // Randomized traffic with backpressure and occasional clear, scored by the model.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                s_tvalid[i] = ($urandom_range(0, 3) != 0);
                s_tdata[i]  = $urandom;
                m_tready[i] = ($urandom_range(0, 2) != 0);
                clear[i]    = ($urandom_range(0, 63) == 0);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0; clear[i] = 1'b0; m_tready[i] = 1'b1;
        end
        repeat (10) @(posedge clk); #1;
        chk("drain_q0", 0, 64'(expq0.size()), 64'd0);
        chk("drain_q1", 1, 64'(expq1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
